// File: rtl/dumb_pkg.sv
// Shared constants and types for the execute/writeback stage.
// Opcodes, flag bit positions, width defaults and run/halt state encoding.
package dumb_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_RA_W     = 3;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Opcodes 0-7 reach the ALU; 8-14 are illegal; 15 is HALT.
  function automatic logic op_is_alu(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op[3] && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/dregfile.sv
// Register file: NUM_REGS x DATA_W, two read ports plus a debug read port.
// Ports: clk, rst (sync high), ra1/rd1, ra2/rd2, dbg_addr/dbg_data, we/wa/wd.
module dregfile
  import dumb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int RA_W     = DEF_RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  assign rd1      = mem_q[ra1];
  assign rd2      = mem_q[ra2];
  assign dbg_data = mem_q[dbg_addr];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/dexec_stage.sv
// Execute/writeback stage around an external combinational 16-bit ALU.
// Ports: in_* handshake/decode, resume, alu_* drive/return, flags_q,
// wb_* writeback pulse, illegal (sticky), dbg_addr/dbg_data peek.
module dexec_stage
  import dumb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int RA_W     = DEF_RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_wb_en,
  input  logic              in_flags_en,
  input  logic              resume,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e state_q, state_d;

  logic              ex_valid_q, ex_valid_d;
  logic [3:0]        ex_op_q, ex_op_d;
  logic [RA_W-1:0]   ex_rd_q, ex_rd_d;
  logic              ex_wb_en_q, ex_wb_en_d;
  logic              ex_flags_en_q, ex_flags_en_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;

  logic [3:0]        flags_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              illegal_q, illegal_d;

  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic              accept;
  logic              wb_we;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  assign in_ready = (state_q == ST_RUN) & ~rst;
  assign accept   = in_valid & in_ready;
  assign wb_we    = ex_valid_q & ex_wb_en_q;

  // The instruction in EX has not written yet; take its result directly.
  assign hit_a = wb_we && (ex_rd_q == in_rs1);
  assign hit_b = wb_we && (ex_rd_q == in_rs2);
  assign fwd_a = hit_a ? alu_out : rf_rd1;
  assign fwd_b = hit_b ? alu_out : rf_rd2;

  assign alu_A    = ex_a_q;
  assign alu_B    = ex_b_q;
  assign alu_op   = ex_op_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign illegal  = illegal_q;

  dregfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RA_W     (RA_W)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra1      (in_rs1),
    .rd1      (rf_rd1),
    .ra2      (in_rs2),
    .rd2      (rf_rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_we),
    .wa       (ex_rd_q),
    .wd       (alu_out)
  );

  always_comb begin
    ex_valid_d    = accept;
    ex_op_d       = ex_op_q;
    ex_rd_d       = ex_rd_q;
    ex_wb_en_d    = ex_wb_en_q;
    ex_flags_en_d = ex_flags_en_q;
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    flags_d       = flags_q;
    wb_valid_d    = wb_we;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    illegal_d     = illegal_q;
    state_d       = state_q;

    if (accept) begin
      ex_op_d       = in_op;
      ex_rd_d       = in_rd;
      // Illegal and HALT ride through EX as NOPs.
      ex_wb_en_d    = in_wb_en & op_is_alu(in_op);
      ex_flags_en_d = in_flags_en & op_is_alu(in_op);
      ex_a_d        = fwd_a;
      ex_b_d        = in_use_imm ? in_imm : fwd_b;
      if (op_is_illegal(in_op)) illegal_d = 1'b1;
    end

    if (wb_we) begin
      wb_rd_d   = ex_rd_q;
      wb_data_d = alu_out;
    end

    if (ex_valid_q && ex_flags_en_q)
      flags_d = alu_flags;

    unique case (state_q)
      ST_RUN:
        if (accept && in_op == OP_HALT)
          state_d = ST_HALTED;
      ST_HALTED:
        if (resume)
          state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      ex_valid_q    <= 1'b0;
      ex_op_q       <= '0;
      ex_rd_q       <= '0;
      ex_wb_en_q    <= 1'b0;
      ex_flags_en_q <= 1'b0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      flags_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ex_valid_q    <= ex_valid_d;
      ex_op_q       <= ex_op_d;
      ex_rd_q       <= ex_rd_d;
      ex_wb_en_q    <= ex_wb_en_d;
      ex_flags_en_q <= ex_flags_en_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      flags_q       <= flags_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      illegal_q     <= illegal_d;
    end
  end

endmodule

// File: tb/tb_dexec_stage.sv
// Bench for dexec_stage: directed program plus random traffic,
// checked against an in-order architectural model with a 1-deep delay.
module tb_dexec_stage;
  import dumb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        in_wb_en, in_flags_en, resume;
  logic [15:0] alu_A, alu_B, alu_out;
  logic [3:0]  alu_op, alu_flags, flags_q;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dexec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_wb_en(in_wb_en), .in_flags_en(in_flags_en),
    .resume(resume),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .flags_q(flags_q),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU behaviour: returns {V,S,C,Z,result}.
  function automatic logic [19:0] alu_fn(input logic [3:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: r = b;
      4'd1: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd2: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: begin r = a >> 1; c = a[0]; end
      4'd7: begin r = a << 1; c = a[15]; end
      default: r = '0;
    endcase
    return {v, r[15], c, (r == 16'd0), r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_fn(alu_op, alu_A, alu_B);

  // Architectural model: arch updates at accept, vis lags one edge.
  logic [15:0] arch [8];
  logic [15:0] vis  [8];
  logic [3:0]  m_flags;
  logic        m_halted, m_illegal;
  logic        pend_v, pend_we, pend_fe;
  logic [2:0]  pend_rd;
  logic [15:0] pend_res;
  logic [3:0]  pend_fl;
  logic        e_wb_v;
  logic [2:0]  e_wb_rd;
  logic [15:0] e_wb_data;
  logic [15:0] e_a, e_b;
  logic [3:0]  e_op;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      arch[i] = '0;
      vis[i]  = '0;
    end
    m_flags = '0; m_halted = 1'b0; m_illegal = 1'b0;
    pend_v = 1'b0; pend_we = 1'b0; pend_fe = 1'b0;
    pend_rd = '0; pend_res = '0; pend_fl = '0;
    e_wb_v = 1'b0; e_wb_rd = '0; e_wb_data = '0;
    e_a = '0; e_b = '0; e_op = '0;
  endtask

  task automatic model_edge(input logic acc);
    logic [15:0] a, b;
    logic [19:0] res;
    logic        legal;
    if (rst) begin
      model_clear();
      return;
    end
    e_wb_v = pend_v && pend_we;
    if (e_wb_v) begin
      vis[pend_rd] = pend_res;
      e_wb_rd      = pend_rd;
      e_wb_data    = pend_res;
    end
    if (pend_v && pend_fe) m_flags = pend_fl;
    if (m_halted && resume) m_halted = 1'b0;
    if (acc) begin
      a     = arch[in_rs1];
      b     = in_use_imm ? in_imm : arch[in_rs2];
      legal = (in_op < 4'd8);
      res   = alu_fn(in_op, a, b);
      pend_we  = in_wb_en && legal;
      pend_fe  = in_flags_en && legal;
      pend_rd  = in_rd;
      pend_res = res[15:0];
      pend_fl  = res[19:16];
      if (pend_we) arch[in_rd] = res[15:0];
      if (in_op >= 4'd8 && in_op != 4'hF) m_illegal = 1'b1;
      if (in_op == 4'hF) m_halted = 1'b1;
      e_a = a; e_b = b; e_op = in_op;
    end
    pend_v = acc;
  endtask

  // Called at a negedge with inputs already set.
  task automatic step();
    logic rdy, acc;
    #1;
    rdy = !m_halted && !rst;
    acc = in_valid && rdy;
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    model_edge(acc);
    @(negedge clk);
    chk("wb_valid", wb_valid, e_wb_v);
    chk("wb_rd", wb_rd, e_wb_rd);
    chk("wb_data", wb_data, e_wb_data);
    chk("flags_q", flags_q, m_flags);
    chk("illegal", illegal, m_illegal);
    chk("alu_A", alu_A, e_a);
    chk("alu_B", alu_B, e_b);
    chk("alu_op", alu_op, e_op);
    chk("dbg_data", dbg_data, vis[dbg_addr]);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic ui, input logic [15:0] imm,
                       input logic we, input logic fe);
    in_valid = 1'b1; in_op = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_use_imm = ui;
    in_imm = imm; in_wb_en = we; in_flags_en = fe;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] r,
                         input logic [15:0] v);
    dbg_addr = r;
    #1;
    chk(tag, dbg_data, v);
  endtask

  initial begin
    model_clear();
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_use_imm = 1'b0; in_imm = '0;
    in_wb_en = 1'b0; in_flags_en = 1'b0; resume = 1'b0;
    dbg_addr = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    idle(1);

    // back-to-back forwarding
    issue(OP_PASS, 3'd1, 3'd0, 3'd0, 1'b1, 16'd250, 1'b1, 1'b1);
    issue(OP_PASS, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7, 1'b1, 1'b1);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1'b1, 1'b1);
    idle(2);
    chk_reg("fwd_r3", 3'd3, 16'd257);
    chk("fwd_flags", flags_q, 4'b0000);

    // zero flag and wb pulse
    issue(OP_SUB, 3'd4, 3'd1, 3'd1, 1'b0, 16'd0, 1'b1, 1'b1);
    idle(1);
    chk("sub_wb_valid", wb_valid, 1'b1);
    chk("sub_wb_rd", wb_rd, 3'd4);
    chk("sub_wb_data", wb_data, 16'd0);
    chk("sub_zero", flags_q[0], 1'b1);
    idle(1);
    chk("sub_wb_once", wb_valid, 1'b0);

    // carry out of shift
    issue(OP_PASS, 3'd5, 3'd0, 3'd0, 1'b1, 16'h8000, 1'b1, 1'b0);
    issue(OP_SHL, 3'd6, 3'd5, 3'd0, 1'b1, 16'd1, 1'b1, 1'b1);
    idle(2);
    chk_reg("shl_r6", 3'd6, 16'd0);
    chk("shl_cz", flags_q[1:0], 2'b11);

    // halt, stalled ADD, resume
    issue(OP_HALT, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    in_valid = 1'b1; in_op = OP_ADD; in_rd = 3'd7;
    in_rs1 = 3'd1; in_rs2 = 3'd1; in_use_imm = 1'b0;
    in_wb_en = 1'b1; in_flags_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_ready", in_ready, 1'b0);
    end
    chk_reg("halt_r7", 3'd7, 16'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    step();
    idle(2);
    chk_reg("resume_r7", 3'd7, 16'd500);

    // illegal opcode is a sticky NOP
    issue(4'd9, 3'd1, 3'd2, 3'd2, 1'b0, 16'd0, 1'b1, 1'b1);
    idle(2);
    chk_reg("ill_r1", 3'd1, 16'd250);
    chk("ill_set", illegal, 1'b1);
    issue(OP_PASS, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3, 1'b1, 1'b0);
    idle(2);
    chk("ill_sticky", illegal, 1'b1);

    // reset with ADD in flight
    issue(OP_ADD, 3'd7, 3'd1, 3'd2, 1'b0, 16'd0, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    chk_reg("rst_r7", 3'd7, 16'd0);
    chk("rst_wb", wb_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 19))
        0:       in_op = 4'(8 + $urandom_range(0, 6));
        1:       in_op = 4'hF;
        default: in_op = 4'($urandom_range(0, 7));
      endcase
      in_rd       = 3'($urandom_range(0, 7));
      in_rs1      = 3'($urandom_range(0, 7));
      in_rs2      = 3'($urandom_range(0, 7));
      in_use_imm  = 1'($urandom_range(0, 1));
      in_imm      = 16'($urandom);
      in_wb_en    = ($urandom_range(0, 7) != 0);
      in_flags_en = 1'($urandom_range(0, 1));
      resume      = ($urandom_range(0, 3) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      dbg_addr    = 3'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0; resume = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
